// File: rtl/sdram_word_bridge.sv
// sdram_word_bridge
//   Bridges a 16-bit-word CPU request/response port onto a 64-bit-beat SDRAM
//   command port. There is one SDRAM command in flight at a time. An optional
//   single-entry 64-bit read line buffer serves repeat reads of the same beat
//   without an SDRAM access. CPU writes go through to SDRAM. A write that hits
//   the buffered beat also updates the buffer when SDRAM acknowledges it.
//   A programmable wait timeout aborts a command that SDRAM never acknowledges.
//
// Parameters
//   LINE_BUF_EN : 1 = enable the read line buffer, 0 = every read goes to SDRAM
//   TIMEOUT     : max wait cycles for sdram_acknowledge, 0 = wait forever
//
// Ports
//   clk, reset_n            : clock (rising edge) and async active-low reset
//   cpu_req_valid/ready     : request handshake; ready only while idle
//   cpu_req_write           : 1 = write, 0 = read
//   cpu_req_addr [29:0]     : 16-bit-word address
//   cpu_req_be   [1:0]      : byte enables of the word
//   cpu_req_wdata[15:0]     : write data
//   cpu_rsp_valid           : one-cycle pulse per accepted request
//   cpu_rsp_rdata[15:0]     : read data (0 for writes and errors)
//   cpu_rsp_error           : request timed out
//   sdram_address[27:0]     : beat address (word address >> 2)
//   sdram_byte_enable[7:0]  : lane-shifted byte enables (all set for reads)
//   sdram_read/sdram_write  : command strobes, held until acknowledge
//   sdram_write_data[63:0]  : write word replicated on all four lanes
//   sdram_acknowledge       : completes the outstanding command
//   sdram_read_data[63:0]   : read beat, sampled with acknowledge

// Next-state value of one 16-bit lane of the line buffer.
module sdram_word_bridge_lane #(
    parameter int VEC_W = 16
) (
    input  logic [VEC_W-1:0]   cur_i,  // current buffer contents
    input  logic [VEC_W-1:0]   rd_i,   // this lane of the SDRAM read beat
    input  logic [VEC_W-1:0]   wr_i,   // CPU write data
    input  logic [VEC_W/8-1:0] be_i,   // byte enables for this lane
    input  logic               ld_i,   // refill from SDRAM
    input  logic               st_i,   // write-through merge
    output logic [VEC_W-1:0]   nxt_o
);
    always_comb begin
        nxt_o = cur_i;
        if (ld_i) begin
            nxt_o = rd_i;
        end else if (st_i) begin
            for (int b = 0; b < VEC_W/8; b++) begin
                if (be_i[b]) nxt_o[8*b +: 8] = wr_i[8*b +: 8];
            end
        end
    end
endmodule

module sdram_word_bridge #(
    parameter int LINE_BUF_EN = 1,
    parameter int TIMEOUT     = 1023
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_req_valid,
    output logic        cpu_req_ready,
    input  logic        cpu_req_write,
    input  logic [29:0] cpu_req_addr,
    input  logic [1:0]  cpu_req_be,
    input  logic [15:0] cpu_req_wdata,
    output logic        cpu_rsp_valid,
    output logic [15:0] cpu_rsp_rdata,
    output logic        cpu_rsp_error,
    output logic [27:0] sdram_address,
    output logic [7:0]  sdram_byte_enable,
    output logic        sdram_read,
    output logic        sdram_write,
    output logic [63:0] sdram_write_data,
    input  logic        sdram_acknowledge,
    input  logic [63:0] sdram_read_data
);
    localparam int NUM_LANES = 4;
    localparam int VEC_W     = 16;
    localparam bit BUF_EN    = (LINE_BUF_EN != 0);
    localparam bit TO_EN     = (TIMEOUT != 0);
    localparam int CW        = TO_EN ? $clog2(TIMEOUT + 1) : 1;
    // Timeout fires on the last allowed wait cycle, so the strobe is high
    // for exactly TIMEOUT cycles.
    localparam int TO_LAST_I = TO_EN ? TIMEOUT - 1 : 0;
    localparam logic [CW-1:0] TO_LAST = TO_LAST_I[CW-1:0];

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, RESP} state_e;

    typedef struct packed {
        logic [29:0] addr;
        logic [15:0] wdata;
    } req_t;

    state_e state_q, state_d;
    req_t   req_q, req_d;
    logic [7:0]    be_q, be_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic [27:0]   tag_q, tag_d;
    logic          bval_q, bval_d;

    logic [NUM_LANES-1:0][VEC_W-1:0] buf_q, buf_d, rd_beat;
    logic buf_ld, buf_st;
    logic hit, buf_match, timeout;

    assign rd_beat = sdram_read_data;

    // Lookup for an incoming read, compared against the live request.
    assign hit = BUF_EN && bval_q && !cpu_req_write && (tag_q == cpu_req_addr[29:2]);
    // Write-through check against the captured request.
    assign buf_match = bval_q && (tag_q == req_q.addr[29:2]);
    // An ack in the same cycle wins over the timeout.
    assign timeout = TO_EN && (cnt_q == TO_LAST) && !sdram_acknowledge;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        be_d    = be_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        tag_d   = tag_q;
        bval_d  = bval_q;
        buf_ld  = 1'b0;
        buf_st  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_req_valid) begin
                    req_d.addr  = cpu_req_addr;
                    req_d.wdata = cpu_req_wdata;
                    cnt_d       = '0;
                    if (cpu_req_write) begin
                        be_d    = {6'b0, cpu_req_be} << {cpu_req_addr[1:0], 1'b0};
                        state_d = WR_WAIT;
                    end else if (hit) begin
                        rdata_d = buf_q[cpu_req_addr[1:0]];
                        err_d   = 1'b0;
                        state_d = RESP;
                    end else begin
                        be_d    = 8'hFF;
                        state_d = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (sdram_acknowledge) begin
                    rdata_d = rd_beat[req_q.addr[1:0]];
                    err_d   = 1'b0;
                    if (BUF_EN) begin
                        buf_ld = 1'b1;
                        tag_d  = req_q.addr[29:2];
                        bval_d = 1'b1;
                    end
                    state_d = RESP;
                end else if (timeout) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    bval_d  = 1'b0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WR_WAIT: begin
                if (sdram_acknowledge) begin
                    rdata_d = '0;
                    err_d   = 1'b0;
                    buf_st  = buf_match;
                    state_d = RESP;
                end else if (timeout) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    bval_d  = 1'b0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        sdram_word_bridge_lane #(.VEC_W(VEC_W)) u_lane (
            .cur_i (buf_q[g]),
            .rd_i  (rd_beat[g]),
            .wr_i  (req_q.wdata),
            .be_i  (be_q[2*g +: 2]),
            .ld_i  (buf_ld),
            .st_i  (buf_st),
            .nxt_o (buf_d[g])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            req_q   <= '0;
            be_q    <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            tag_q   <= '0;
            bval_q  <= 1'b0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            be_q    <= be_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            tag_q   <= tag_d;
            bval_q  <= bval_d;
            buf_q   <= buf_d;
        end
    end

    // Strobes and response valid decode straight from state, so an async
    // reset drops them in the same instant.
    assign cpu_req_ready     = (state_q == IDLE);
    assign cpu_rsp_valid     = (state_q == RESP);
    assign cpu_rsp_rdata     = rdata_q;
    assign cpu_rsp_error     = err_q;
    assign sdram_read        = (state_q == RD_WAIT);
    assign sdram_write       = (state_q == WR_WAIT);
    assign sdram_address     = req_q.addr[29:2];
    assign sdram_byte_enable = be_q;
    assign sdram_write_data  = {NUM_LANES{req_q.wdata}};

endmodule

// File: tb/tb_sdram_word_bridge.sv
module tb_sdram_word_bridge;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_req_valid = 1'b0;
    logic        cpu_req_ready;
    logic        cpu_req_write = 1'b0;
    logic [29:0] cpu_req_addr = '0;
    logic [1:0]  cpu_req_be = '0;
    logic [15:0] cpu_req_wdata = '0;
    logic        cpu_rsp_valid;
    logic [15:0] cpu_rsp_rdata;
    logic        cpu_rsp_error;
    logic [27:0] sdram_address;
    logic [7:0]  sdram_byte_enable;
    logic        sdram_read;
    logic        sdram_write;
    logic [63:0] sdram_write_data;
    logic        sdram_acknowledge = 1'b0;
    logic [63:0] sdram_read_data = '0;

    sdram_word_bridge #(.LINE_BUF_EN(1), .TIMEOUT(4)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .cpu_req_valid     (cpu_req_valid),
        .cpu_req_ready     (cpu_req_ready),
        .cpu_req_write     (cpu_req_write),
        .cpu_req_addr      (cpu_req_addr),
        .cpu_req_be        (cpu_req_be),
        .cpu_req_wdata     (cpu_req_wdata),
        .cpu_rsp_valid     (cpu_rsp_valid),
        .cpu_rsp_rdata     (cpu_rsp_rdata),
        .cpu_rsp_error     (cpu_rsp_error),
        .sdram_address     (sdram_address),
        .sdram_byte_enable (sdram_byte_enable),
        .sdram_read        (sdram_read),
        .sdram_write       (sdram_write),
        .sdram_write_data  (sdram_write_data),
        .sdram_acknowledge (sdram_acknowledge),
        .sdram_read_data   (sdram_read_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] rd;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Response scoreboard: every cpu_rsp_valid pulse must match the oldest
    // expectation; a pulse with nothing outstanding is an error.
    always @(negedge clk) begin
        if (reset_n && cpu_rsp_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_rsp", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_rdata", cpu_rsp_rdata, e.rd);
                chk("rsp_error", cpu_rsp_error, e.err);
            end
        end
    end

    // One CPU transaction with an SDRAM responder that acks on strobe cycle
    // ack_dly (0 = never). While the bridge is busy the CPU side is driven
    // with junk to show it is ignored.
    task automatic do_req(input bit wr, input logic [29:0] addr, input logic [1:0] be,
                          input logic [15:0] wd, input int ack_dly, input logic [63:0] beat,
                          input logic [15:0] exp_rd, input bit exp_err, input int exp_strobes);
        exp_t e;
        logic [7:0] exp_be;
        int  lat, strobes;
        bit  done;
        exp_be = wr ? (8'({be}) << (2 * int'(addr[1:0]))) : 8'hFF;
        e.rd = exp_rd;
        e.err = exp_err;
        @(negedge clk);
        chk("req_ready", cpu_req_ready, 1);
        sb.push_back(e);
        cpu_req_valid = 1'b1;
        cpu_req_write = wr;
        cpu_req_addr  = addr;
        cpu_req_be    = be;
        cpu_req_wdata = wd;
        @(posedge clk);
        #1 cpu_req_valid = 1'b0;
        lat = 0;
        strobes = 0;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            lat++;
            sdram_acknowledge = 1'b0;
            if (cpu_rsp_valid) begin
                done = 1'b1;
                cpu_req_valid = 1'b0;
                chk("ready_in_resp", cpu_req_ready, 0);
                chk("strobe_in_resp", {sdram_read, sdram_write}, 0);
            end else begin
                chk("busy_ready", cpu_req_ready, 0);
                if (sdram_read || sdram_write) begin
                    strobes++;
                    chk("strobe_kind", {sdram_read, sdram_write}, wr ? 2'b01 : 2'b10);
                    chk("sdram_addr", sdram_address, addr[29:2]);
                    chk("sdram_be", sdram_byte_enable, exp_be);
                    if (wr) chk("sdram_wdata", sdram_write_data, {4{wd}});
                    if (strobes == ack_dly) begin
                        sdram_acknowledge = 1'b1;
                        sdram_read_data   = beat;
                    end
                end
                cpu_req_valid = 1'b1;
                cpu_req_write = ~wr;
                cpu_req_addr  = 30'h3FFF_FFFF;
                cpu_req_be    = 2'b11;
                cpu_req_wdata = 16'hDEAD;
            end
        end
        cpu_req_valid = 1'b0;
        sdram_acknowledge = 1'b0;
        if (!done) chk("rsp_never_came", 0, 1);
        chk("strobe_cycles", strobes, exp_strobes);
        chk("rsp_latency", lat, exp_strobes + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    initial begin
        // Reset state (checked while reset is held)
        #2;
        chk("rst_rsp_valid", cpu_rsp_valid, 0);
        chk("rst_strobes", {sdram_read, sdram_write}, 0);
        chk("rst_addr", sdram_address, 0);
        chk("rst_be", sdram_byte_enable, 0);
        chk("rst_wdata", sdram_write_data, 0);
        chk("rst_rdata", {cpu_rsp_error, cpu_rsp_rdata}, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", cpu_req_ready, 1);

        // Miss, ack on third strobe cycle; then hit on same beat
        do_req(0, 30'h5, 2'b11, 16'h0, 3, 64'h4444_3333_2222_1111, 16'h2222, 0, 3);
        do_req(0, 30'h7, 2'b11, 16'h0, 0, 64'h0, 16'h4444, 0, 0);
        // Write-through into buffered beat, upper byte of lane 2
        do_req(1, 30'h6, 2'b10, 16'hAB00, 2, 64'h0, 16'h0000, 0, 2);
        do_req(0, 30'h6, 2'b11, 16'h0, 0, 64'h0, 16'hAB33, 0, 0);
        do_req(0, 30'h4, 2'b11, 16'h0, 0, 64'h0, 16'h1111, 0, 0);
        // Write to another beat leaves buffer alone
        do_req(1, 30'h40, 2'b11, 16'h1234, 1, 64'h0, 16'h0000, 0, 1);
        do_req(0, 30'h5, 2'b11, 16'h0, 0, 64'h0, 16'h2222, 0, 0);
        // Read timeout invalidates buffer
        do_req(0, 30'h100, 2'b11, 16'h0, 0, 64'h0, 16'h0000, 1, 4);
        do_req(0, 30'h5, 2'b11, 16'h0, 2, 64'h4444_3333_2222_1111, 16'h2222, 0, 2);
        do_req(0, 30'h100, 2'b11, 16'h0, 1, 64'h0123_4567_89AB_CDEF, 16'hCDEF, 0, 1);
        // Ack on the last allowed wait cycle is a success
        do_req(0, 30'h202, 2'b11, 16'h0, 4, 64'hDEAD_BEEF_CAFE_F00D, 16'hBEEF, 0, 4);
        do_req(0, 30'h203, 2'b11, 16'h0, 0, 64'h0, 16'hDEAD, 0, 0);
        // Write timeout also invalidates the buffer
        do_req(1, 30'h9, 2'b11, 16'h5555, 0, 64'h0, 16'h0000, 1, 4);
        do_req(0, 30'h203, 2'b11, 16'h0, 1, 64'hDEAD_BEEF_CAFE_F00D, 16'hDEAD, 0, 1);
        // Low-byte write-through in lane 3, then non-matching write in lane 1
        do_req(1, 30'h203, 2'b01, 16'h00AA, 3, 64'h0, 16'h0000, 0, 3);
        do_req(0, 30'h203, 2'b11, 16'h0, 0, 64'h0, 16'hDEAA, 0, 0);
        do_req(1, 30'h1, 2'b11, 16'hFFFF, 1, 64'h0, 16'h0000, 0, 1);
        do_req(0, 30'h202, 2'b11, 16'h0, 0, 64'h0, 16'hBEEF, 0, 0);

        // Stray ack while idle is ignored
        @(negedge clk);
        sdram_acknowledge = 1'b1;
        sdram_read_data = '1;
        @(negedge clk);
        sdram_acknowledge = 1'b0;
        chk("idle_ack_rsp", cpu_rsp_valid, 0);
        chk("idle_ack_ready", cpu_req_ready, 1);
        do_req(0, 30'h202, 2'b11, 16'h0, 0, 64'h0, 16'hBEEF, 0, 0);

        // Reset two cycles into RD_WAIT
        do_req(0, 30'h300, 2'b11, 16'h0, 1, 64'h1111_2222_3333_4444, 16'h4444, 0, 1);
        do_req(0, 30'h301, 2'b11, 16'h0, 0, 64'h0, 16'h3333, 0, 0);
        @(negedge clk);
        cpu_req_valid = 1'b1;
        cpu_req_write = 1'b0;
        cpu_req_addr  = 30'h304;
        @(posedge clk);
        #1 cpu_req_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_read1", sdram_read, 1);
        @(negedge clk);
        chk("pre_rst_read2", sdram_read, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_strobe", {sdram_read, sdram_write}, 0);
        chk("mid_rst_addr", sdram_address, 0);
        chk("mid_rst_be", sdram_byte_enable, 0);
        chk("mid_rst_rsp", cpu_rsp_valid, 0);
        @(negedge clk);
        reset_n = 1'b1;
        sdram_acknowledge = 1'b1;
        sdram_read_data = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        sdram_acknowledge = 1'b0;
        chk("late_ack_rsp", cpu_rsp_valid, 0);
        chk("late_ack_strobe", {sdram_read, sdram_write}, 0);
        // Buffer was invalidated by reset: beat 0xC0 must miss now
        do_req(0, 30'h300, 2'b11, 16'h0, 2, 64'h1111_2222_3333_4444, 16'h4444, 0, 2);

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
